// File: rtl/agu_k2.sv
// agu_k2: radix-2 NTT butterfly index generator for order_translate_k2.
// Sweeps every stage, inserts a drain bubble between stages, flags the last pair.
module agu_k2 #(
  parameter int D_WIDTH   = 32,
  parameter int LOG_N     = 16,
  parameter int STAGE_GAP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [D_WIDTH-1:0] Order_0,
  output logic [D_WIDTH-1:0] Order_1,
  output logic               r_enable_k2,
  output logic               AGU_done_k2,
  output logic [D_WIDTH-1:0] l,
  output logic               busy
);

  localparam int JW = LOG_N - 1;
  localparam int SW = $clog2(LOG_N);
  localparam int GW = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [JW-1:0] j_q, j_d;
  logic [SW-1:0] s_q, s_d;
  logic [GW-1:0] g_q, g_d;

  logic [D_WIDTH-1:0] o0_d, o1_d, l_d;
  logic ren_d, done_d, busy_d;
  logic emit;

  // j/s always name the pair that the next emitting edge will produce
  logic [SW-1:0]    p;
  logic [LOG_N-1:0] jx, bitp, msk, pr0, pr1;

  assign p    = S_LAST - s_q;
  assign jx   = {1'b0, j_q};
  assign bitp = LOG_N'(1) << p;
  assign msk  = bitp - LOG_N'(1);
  assign pr0  = ((jx & ~msk) << 1) | (jx & msk);
  assign pr1  = pr0 | bitp;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    g_d     = g_q;
    o0_d    = Order_0;
    o1_d    = Order_1;
    l_d     = l;
    ren_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy;
    emit    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          emit    = !stall;
        end
      end
      RUN: begin
        if (AGU_done_k2) begin
          state_d = IDLE;
          j_d     = '0;
          s_d     = '0;
          g_d     = '0;
          o0_d    = '0;
          o1_d    = '0;
          l_d     = '0;
          busy_d  = 1'b0;
        end else begin
          emit = !stall;
        end
      end
      GAP: begin
        if (g_q == G_LAST) begin
          state_d = RUN;
          emit    = !stall;
        end else begin
          g_d = g_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      o0_d  = {{(D_WIDTH-LOG_N){1'b0}}, pr0};
      o1_d  = {{(D_WIDTH-LOG_N){1'b0}}, pr1};
      l_d   = {{(D_WIDTH-SW){1'b0}}, s_q};
      ren_d = 1'b1;
      if (j_q != J_LAST) begin
        j_d = j_q + JW'(1);
      end else if (s_q == S_LAST) begin
        done_d = 1'b1;
      end else begin
        j_d = '0;
        s_d = s_q + SW'(1);
        if (STAGE_GAP > 0) begin
          state_d = GAP;
          g_d     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      s_q         <= '0;
      g_q         <= '0;
      Order_0     <= '0;
      Order_1     <= '0;
      l           <= '0;
      r_enable_k2 <= 1'b0;
      AGU_done_k2 <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      s_q         <= s_d;
      g_q         <= g_d;
      Order_0     <= o0_d;
      Order_1     <= o1_d;
      l           <= l_d;
      r_enable_k2 <= ren_d;
      AGU_done_k2 <= done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_agu_k2.sv
// tb_agu_k2: directed vector tables for agu_k2 (N=16) plus
// a pair scoreboard on an N=64 instance.
module tb_agu_k2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, stall_a = 1'b0;
  logic start_b = 1'b0, stall_b = 1'b0;
  logic start_c = 1'b0, stall_c = 1'b0;

  logic [31:0] o0_a, o1_a, l_a;
  logic [31:0] o0_b, o1_b, l_b;
  logic [31:0] o0_c, o1_c, l_c;
  logic ren_a, done_a, busy_a;
  logic ren_b, done_b, busy_b;
  logic ren_c, done_c, busy_c;

  agu_k2 #(.D_WIDTH(32), .LOG_N(4), .STAGE_GAP(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stall(stall_a),
    .Order_0(o0_a), .Order_1(o1_a), .r_enable_k2(ren_a),
    .AGU_done_k2(done_a), .l(l_a), .busy(busy_a)
  );

  agu_k2 #(.D_WIDTH(32), .LOG_N(4), .STAGE_GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall_b),
    .Order_0(o0_b), .Order_1(o1_b), .r_enable_k2(ren_b),
    .AGU_done_k2(done_b), .l(l_b), .busy(busy_b)
  );

  agu_k2 #(.D_WIDTH(32), .LOG_N(6), .STAGE_GAP(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stall(stall_c),
    .Order_0(o0_c), .Order_1(o1_c), .r_enable_k2(ren_c),
    .AGU_done_k2(done_c), .l(l_c), .busy(busy_c)
  );

  typedef struct {
    logic start;
    logic stall;
    logic ren;
    logic done;
    logic busy;
    int   o0;
    int   o1;
    int   l;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void add(input logic st, input logic sl,
                              input logic rn, input logic dn,
                              input logic bz, input int a,
                              input int b, input int c);
    vec_t v;
    v.start = st; v.stall = sl; v.ren = rn; v.done = dn;
    v.busy = bz; v.o0 = a; v.o1 = b; v.l = c;
    vecs.push_back(v);
  endfunction

  // expected N=16 sweep: pair j of stage s is block j/half, offset j%half
  function automatic void build(input int gap, input int stall_j,
                                input bit gap_stall, input bit first_start,
                                input bit extra_start);
    int lo0, lo1, ll, half, a;
    bit st;
    lo0 = 0; lo1 = 0; ll = 0;
    for (int s = 0; s < 4; s++) begin
      half = 1 << (3 - s);
      for (int j = 0; j < 8; j++) begin
        a = (j / half) * 2 * half + j % half;
        if (s > 0 && j == 0) begin
          for (int g = 0; g < gap; g++)
            add(1'b0, gap_stall, 1'b0, 1'b0, 1'b1, lo0, lo1, ll);
          if (gap_stall)
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, lo0, lo1, ll);
        end
        if (s == 0 && j == stall_j)
          for (int k = 0; k < 3; k++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, lo0, lo1, ll);
        st = (s == 0 && j == 0 && first_start) ||
             (extra_start && s == 1 && j == 3);
        add(st, 1'b0, 1'b1, (s == 3 && j == 7), 1'b1, a, a + half, s);
        lo0 = a; lo1 = a + half; ll = s;
      end
    end
    add(extra_start, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endfunction

  task automatic cmp(input string nm, input logic rn, input logic dn,
                     input logic bz, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c,
                     input vec_t e);
    n_vec++;
    if (rn !== e.ren || dn !== e.done || bz !== e.busy ||
        a !== e.o0 || b !== e.o1 || c !== e.l) begin
      n_bad++;
      $display("FAIL %s: got ren=%b done=%b busy=%b o0=%0d o1=%0d l=%0d, want ren=%b done=%b busy=%b o0=%0d o1=%0d l=%0d",
               nm, rn, dn, bz, a, b, c,
               e.ren, e.done, e.busy, e.o0, e.o1, e.l);
    end
  endtask

  task automatic run(input int sel, input string tag);
    vec_t e;
    string nm;
    foreach (vecs[i]) begin
      e = vecs[i];
      if (sel == 0) begin
        start_a = e.start; stall_a = e.stall;
      end else begin
        start_b = e.start; stall_b = e.stall;
      end
      @(posedge clk);
      #1;
      nm = $sformatf("%s[%0d]", tag, i);
      if (sel == 0)
        cmp(nm, ren_a, done_a, busy_a, o0_a, o1_a, l_a, e);
      else
        cmp(nm, ren_b, done_b, busy_b, o0_b, o1_b, l_b, e);
    end
    start_a = 1'b0; stall_a = 1'b0;
    start_b = 1'b0; stall_b = 1'b0;
    vecs.delete();
  endtask

  task automatic check(input string nm, input bit ok, input string info);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", nm, info);
    end
  endtask

  vec_t zero_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
  vec_t mid_v  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 6, 2};

  bit seen[6][64];
  int nv, nb, cyc, lv, pp;
  bit ok, last_ok, all;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_a", ren_a, done_a, busy_a, o0_a, o1_a, l_a, zero_v);
    cmp("reset_b", ren_b, done_b, busy_b, o0_b, o1_b, l_b, zero_v);
    rst = 1'b1;

    build(4, -1, 1'b0, 1'b1, 1'b1);
    run(0, "sweep");

    build(4, 2, 1'b1, 1'b1, 1'b0);
    run(0, "stall");

    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    build(0, -1, 1'b0, 1'b0, 1'b0);
    run(1, "nogap");

    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    cmp("mid_stage2", ren_a, done_a, busy_a, o0_a, o1_a, l_a, mid_v);
    #3 rst = 1'b0;
    #1;
    cmp("async_rst", ren_a, done_a, busy_a, o0_a, o1_a, l_a, zero_v);
    #2 rst = 1'b1;
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 8, 0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 9, 0);
    run(0, "restart");

    nv = 0; nb = 0; cyc = 0; last_ok = 0;
    start_c = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    while (busy_c === 1'b1 && cyc < 400) begin
      nb++;
      if (ren_c === 1'b1) begin
        lv = int'(l_c);
        ok = (lv < 6) && (o1_c < 64);
        if (ok) begin
          pp = 5 - lv;
          ok = (o1_c == o0_c + (32'd1 << pp)) && (o0_c[pp] == 1'b0) &&
               !seen[lv][o0_c] && !seen[lv][o1_c] &&
               (done_c === (nv == 191));
          seen[lv][o0_c] = 1'b1;
          seen[lv][o1_c] = 1'b1;
        end
        check($sformatf("pair%0d", nv), ok,
              $sformatf("got o0=%0d o1=%0d l=%0d done=%b", o0_c, o1_c, l_c, done_c));
        if (done_c === 1'b1)
          last_ok = (o0_c == 62) && (o1_c == 63) && (lv == 5);
        nv++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sb_timeout", cyc < 400, $sformatf("busy stuck after %0d cycles", cyc));
    check("sb_valid", nv == 192, $sformatf("got %0d valid, want 192", nv));
    check("sb_busy", nb == 197, $sformatf("got %0d busy, want 197", nb));
    check("sb_last", last_ok, "last pair not (62,63) at l=5 with done");
    for (int s = 0; s < 6; s++) begin
      all = 1'b1;
      for (int k = 0; k < 64; k++) if (!seen[s][k]) all = 1'b0;
      check($sformatf("cover_l%0d", s), all, "index missing in stage");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/agu_k2.md
Name: agu_k2

Overview:
- Address generation unit that feeds order_translate_k2.
- Sweeps every radix-2 NTT stage of an N = 2^LOG_N point transform and emits one butterfly index pair (Order_0, Order_1) per cycle, qualified by r_enable_k2, with the current stage number on l.
- Inserts a programmable bubble between stages so the downstream translate/memory pipeline drains before the next stage.
- Flags the final pair with AGU_done_k2.

Parameters:
- D_WIDTH, 32: width of Order_0, Order_1 and l; equals `D_width.
- LOG_N, 16: log2 of transform length; equals `degree_width; legal range 2..D_WIDTH-1.
- STAGE_GAP, 4: idle cycles inserted between consecutive stages; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- start  in  1  one-cycle request to begin a full transform sweep.
- stall  in  1  hold request; while 1, generation is frozen.
- Order_0  out  D_WIDTH  lower index of the butterfly pair.
- Order_1  out  D_WIDTH  upper index, equal to Order_0 + 2^p.
- r_enable_k2  out  1  Order_0/Order_1/l valid this cycle.
- AGU_done_k2  out  1  high with the last valid pair of the last stage.
- l  out  D_WIDTH  stage index of the current pair, 0..LOG_N-1.
- busy  out  1  sweep in progress.

Behaviour:
- Reset:
  - rst = 0 forces state IDLE immediately (asynchronous).
  - Clears pair counter j, stage counter, gap counter and all outputs to 0.
  - Reset mid-sweep aborts the sweep; no resume.
- All outputs are registered.
- Index rule for stage l:
  - p = LOG_N-1-l; j runs 0..N/2-1.
  - Order_0 = ((j >> p) << (p+1)) | (j & (2^p - 1)), i.e. a 0 inserted at bit p of j.
  - Order_1 = Order_0 | 2^p.
  - Both are zero-extended to D_WIDTH.
- States: IDLE, RUN, GAP.
- IDLE:
  - All outputs 0.
  - stall is ignored.
  - start = 1 at an edge moves to RUN and loads the j=0, l=0 pair into the outputs at that same edge, with r_enable_k2 = 1 and busy = 1. Latency start to first valid pair is 1 cycle.
- RUN, stall = 0:
  - Each edge emits the next j with r_enable_k2 = 1.
  - After emitting j = N/2-1 of stage l < LOG_N-1: if STAGE_GAP > 0, the next edge enters GAP; if STAGE_GAP = 0, the next edge emits j = 0 of stage l+1 (no bubble).
- RUN, stall = 1 at an edge:
  - Counters hold.
  - r_enable_k2 and AGU_done_k2 become 0.
  - Order_0, Order_1 and l hold their last values.
  - The first edge with stall = 0 emits the pair that was pending.
- GAP:
  - r_enable_k2 = 0; Order/l hold; busy = 1.
  - The gap counter counts exactly STAGE_GAP cycles and ignores stall.
  - The edge that ends the gap emits j = 0 of stage l+1 (l output increments).
  - A stall asserted on that edge takes precedence: no emit, remain pending in RUN.
- Last pair (l = LOG_N-1, j = N/2-1):
  - Emitted with r_enable_k2 = 1 and AGU_done_k2 = 1 in the same cycle.
  - The following edge returns to IDLE: all outputs 0, busy = 0.
- start while busy = 1 is ignored, including on the cycle of the last pair.
- start in IDLE together with stall = 1: the sweep is accepted but the first pair is held pending, so r_enable_k2 stays 0.
- Valid cycle count per sweep is LOG_N·N/2, independent of stalls.
- Unstalled busy duration is LOG_N·N/2 + (LOG_N-1)·STAGE_GAP cycles.
- j width is LOG_N-1 bits; the stage counter saturates at its terminal value, and neither counter wraps.

Test Plan:
- LOG_N=4, STAGE_GAP=4, start pulse, no stall -> stage 0 pairs (0,8),(1,9)…(7,15); stage 1 (0,4),(1,5),(2,6),(3,7),(8,12)…(11,15); stage 3 (0,1)…(14,15). 32 valid cycles; 4-cycle r_enable_k2=0 gaps between stages; busy high 44 cycles; AGU_done_k2 high only with (14,15), l=3.
- Same config, stall high 3 cycles while (2,10) is pending -> r_enable_k2=0 for 3 cycles with outputs holding (1,9); (2,10) is emitted on the first unstalled edge; no pair is lost or duplicated.
- STAGE_GAP=0 -> pair (7,15) at l=0 is followed directly by (0,4) at l=1; busy high 32 cycles.
- start reasserted mid-sweep and again on the AGU_done_k2 cycle -> no effect; exactly one sweep occurs; IDLE is reached the cycle after (14,15).
- rst driven 0 asynchronously mid-stage-2 -> all outputs 0 immediately without a clock edge; after release, a new start restarts at (0,8), l=0.
- LOG_N=16 default, no stall -> 524288 valid cycles; last pair (65534,65535) at l=15 carries AGU_done_k2; a scoreboard confirms every index appears exactly once per stage.
